fsk_rate_gen: RTL and testbench
===============================

Name: fsk_rate_gen

Overview:
- Parametrised, programmable successor to the fixed divide-by-16 data-rate toggler.
- Produces a square-wave tone whose half-period is selected per symbol by an input data bit (binary FSK), for driving the backscatter switch.
- Accepts bits through a valid/ready handshake into a one-entry holding register and times symbols with a programmable symbol counter.
- Sits between the packet/bit source and the RF switch driver.

Parameters:
CNT_W, 12, width of divider counter and div0/div1 inputs
SYM_W, 16, width of symbol-length counter and sym_len input
CONT_PHASE, 1, 1 = divider counter not cleared at symbol boundaries (continuous phase); 0 = cleared at every symbol load

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run enable; 0 = synchronous abort to IDLE
div0  in  CNT_W  half-period minus 1, in cycles, for bit 0
div1  in  CNT_W  half-period minus 1, in cycles, for bit 1
sym_len  in  SYM_W  clock cycles per symbol; 0 treated as 1
bit_in  in  1  data bit
bit_valid  in  1  bit_in valid
bit_ready  out  1  holding register empty (= !hold_full, combinational)
tone_out  out  1  FSK square wave to switch driver
sym_strobe  out  1  one-cycle pulse on the last cycle of each symbol
busy  out  1  high in RUN
frame_done  out  1  one-cycle pulse when RUN ends because no bit is pending

Behaviour:
- Reset values: tone_out=0, sym_strobe=0, busy=0, frame_done=0, hold_full=0, both counters=0, state=IDLE.
- Handshake: a bit is accepted on a clock edge where bit_valid && bit_ready, which sets hold_full. bit_valid with bit_ready=0 is ignored; the source must hold.
- State IDLE:
  - tone_out=0; counters held at 0.
  - If enable && hold_full: latch cur_bit, latch cur_div (div0 or div1), clear hold_full, go to RUN. busy=1 from the next cycle.
  - Latency from acceptance to the first RUN cycle is 1 cycle.
- State RUN, divider:
  - div_cnt increments each cycle.
  - When div_cnt >= cur_div: toggle tone_out and set div_cnt to 0.
  - Half-period is therefore cur_div+1 cycles. cur_div=0 toggles every cycle.
- State RUN, symbol timing:
  - sym_cnt counts 0..max(sym_len,1)-1; sym_strobe=1 while sym_cnt is at the last value.
  - On that last cycle, if hold_full: load the next bit and divisor, clear hold_full, set sym_cnt to 0, stay in RUN.
  - On that last cycle, if !hold_full: go to IDLE, force tone_out to 0 on the same edge, pulse frame_done for one cycle.
- div0, div1 and sym_len are sampled only at symbol load. Changes mid-symbol have no effect until the next symbol.
- Symbol boundary with CONT_PHASE=1:
  - div_cnt continues into the new symbol.
  - If div_cnt >= the new cur_div, the toggle and wrap happen on the first cycle of the new symbol (the >= compare; no lockout).
  - A toggle coinciding with the boundary edge is applied normally.
- Symbol boundary with CONT_PHASE=0: div_cnt is cleared on every load.
- Same-edge events:
  - An acceptance on the boundary edge is not possible, because bit_ready=0 while hold_full.
  - An acceptance on the cycle after a load is allowed.
- enable=0 in any state: on the next edge go to IDLE, set tone_out=0, clear hold_full and both counters. frame_done is not pulsed.
- Reset asserted mid-operation: all outputs return immediately to their reset values.

Decomposition:
- Shared package fsk_rate_pkg:
  - state enum {IDLE, RUN}
  - default constants DEF_DIV0=15 and DEF_DIV1=7
  - DEF_SYM_LEN=64
- Sub-module rate_divider:
  - ports: clock, reset, run, clr, div, tone
  - programmable half-period toggle divider with >= compare
  - reusable by the other rate blocks

Test Plan:
- Reset: assert reset mid-RUN with tone_out=1 -> all outputs 0 immediately; bit_ready=1 after release.
- Single bit 0, div0=15, sym_len=64 -> tone_out toggles on RUN cycles 16, 32, 48, 64 and is 0 at the end. sym_strobe on cycle 64, frame_done on the next cycle, busy high for exactly 64 cycles.
- Bits 0 then 1 back-to-back, div0=15, div1=7, sym_len=64, CONT_PHASE=1 -> no gap between symbols; second symbol half-period is 8 cycles; exactly one sym_strobe per symbol.
- Wrap boundary, CONT_PHASE=1, div0=15, div1=3, sym_len=10 -> div_cnt=9 at the boundary, so tone toggles on the first cycle of the second symbol, then every 4 cycles. With CONT_PHASE=0, the first toggle is on cycle 4.
- Handshake/backpressure: bit_valid held high continuously -> bit_ready low while hold_full; every bit accepted exactly once; output sequence matches input order.
- Abort: enable dropped mid-symbol with a bit pending -> next edge IDLE, tone_out=0, hold cleared, frame_done stays 0.

Source files
------------

// File: rtl/fsk_rate_pkg.sv
// rtl/fsk_rate_pkg.sv - shared state type and default rates for the FSK rate generator
package fsk_rate_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_DIV0    = 15;
   localparam int DEF_DIV1    = 7;
   localparam int DEF_SYM_LEN = 64;

endpackage

// File: rtl/rate_divider.sv
// rtl/rate_divider.sv - programmable half-period toggle divider with >= compare
module rate_divider #(
   parameter int CNT_W = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic             clr,
   input  logic [CNT_W-1:0] div,
   output logic             tone
);
   logic [CNT_W-1:0] cnt;
   logic             wrap;

   // >= so that a count carried past a newly shortened divisor wraps at once
   assign wrap = (cnt >= div);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (!run) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else begin
         if (wrap) begin
            tone <= ~tone;
         end
         if (wrap || clr) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsk_rate_gen.sv
// rtl/fsk_rate_gen.sv - binary FSK tone generator with bit handshake and symbol timing
module fsk_rate_gen
   import fsk_rate_pkg::*;
#(
   parameter int CNT_W      = 12,
   parameter int SYM_W      = 16,
   parameter bit CONT_PHASE = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] div0,
   input  logic [CNT_W-1:0] div1,
   input  logic [SYM_W-1:0] sym_len,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic             tone_out,
   output logic             sym_strobe,
   output logic             busy,
   output logic             frame_done
);
   state_t           state;
   state_t           state_nxt;
   logic             hold_full;
   logic             hold_bit;
   logic [CNT_W-1:0] cur_div;
   logic [SYM_W-1:0] cur_last;
   logic [SYM_W-1:0] sym_cnt;
   logic             last_cyc;
   logic             load;
   logic             end_frame;
   logic             div_run;
   logic             div_clr;

   assign bit_ready = !hold_full;
   assign last_cyc  = (sym_cnt == cur_last);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (hold_full) state_nxt = RUN;
            RUN:     if (last_cyc && !hold_full) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy       = (state == RUN);
      sym_strobe = busy && last_cyc;
      load       = enable && hold_full && ((state == IDLE) || last_cyc);
      end_frame  = enable && sym_strobe && !hold_full;
      // Dropping run on the final edge forces the tone low together with the return to IDLE
      div_run    = enable && busy && !end_frame;
      div_clr    = !CONT_PHASE && load;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_full  <= 1'b0;
         hold_bit   <= 1'b0;
         cur_div    <= '0;
         cur_last   <= '0;
         sym_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         if (!enable || load) begin
            hold_full <= 1'b0;
         end else if (bit_valid && bit_ready) begin
            hold_full <= 1'b1;
            hold_bit  <= bit_in;
         end
         // Divisor and symbol length are captured only here, so mid-symbol edits wait for the next load
         if (load) begin
            cur_div  <= hold_bit ? div1 : div0;
            cur_last <= (sym_len == '0) ? '0 : sym_len - 1'b1;
         end
         if (!enable || !busy || last_cyc) begin
            sym_cnt <= '0;
         end else begin
            sym_cnt <= sym_cnt + 1'b1;
         end
         frame_done <= end_frame;
      end
   end

   rate_divider #(
      .CNT_W (CNT_W)
   ) u_div (
      .clock (clock),
      .reset (reset),
      .run   (div_run),
      .clr   (div_clr),
      .div   (cur_div),
      .tone  (tone_out)
   );

endmodule

// File: tb/tb_fsk_rate_gen.sv
// tb/tb_fsk_rate_gen.sv - self-checking bench for fsk_rate_gen, both phase modes side by side
module tb_fsk_rate_gen;
   localparam int CNT_W = 12;
   localparam int SYM_W = 16;

   logic             clock     = 1'b0;
   logic             reset     = 1'b0;
   logic             enable    = 1'b0;
   logic             bit_in    = 1'b0;
   logic             bit_valid = 1'b0;
   logic [CNT_W-1:0] div0      = '0;
   logic [CNT_W-1:0] div1      = '0;
   logic [SYM_W-1:0] sym_len   = '0;
   logic             bit_ready, tone_out, sym_strobe, busy, frame_done;
   logic             bit_ready0, tone_out0, sym_strobe0, busy0, frame_done0;

   int checks = 0;
   int errors = 0;
   bit bits[$];
   int fd0, fd1, fl;
   int idx;
   bit pend;
   bit exp_t1[$];
   bit exp_t0[$];

   always #5 clock = ~clock;

   fsk_rate_gen #(.CNT_W(CNT_W), .SYM_W(SYM_W), .CONT_PHASE(1'b1)) dut (
      .clock(clock), .reset(reset), .enable(enable), .div0(div0), .div1(div1),
      .sym_len(sym_len), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
      .tone_out(tone_out), .sym_strobe(sym_strobe), .busy(busy), .frame_done(frame_done)
   );

   fsk_rate_gen #(.CNT_W(CNT_W), .SYM_W(SYM_W), .CONT_PHASE(1'b0)) dut0 (
      .clock(clock), .reset(reset), .enable(enable), .div0(div0), .div1(div1),
      .sym_len(sym_len), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready0),
      .tone_out(tone_out0), .sym_strobe(sym_strobe0), .busy(busy0), .frame_done(frame_done0)
   );

   task automatic chk1(input string tag, input logic obs, input logic want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, want);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, want);
      end
   endtask

   // Tone seen during each RUN cycle: a half-period ends once d+1 cycles have elapsed since the
   // last toggle; without continuous phase the elapsed count restarts with every symbol.
   function automatic void build_model();
      int lr;
      int e;
      int d;
      bit t;
      lr = (fl == 0) ? 1 : fl;
      exp_t1.delete();
      exp_t0.delete();
      for (int cp = 0; cp < 2; cp++) begin
         e = 0;
         t = 1'b0;
         for (int c = 1; c <= bits.size() * lr; c++) begin
            d = bits[(c - 1) / lr] ? fd1 : fd0;
            if (cp == 0 && ((c - 1) % lr) == 0) e = 0;
            if (cp == 1) exp_t1.push_back(t);
            else exp_t0.push_back(t);
            if (e >= d) begin
               t = ~t;
               e = 0;
            end else begin
               e++;
            end
         end
      end
   endfunction

   // Source side: holds bit_valid high while bits remain, advancing on each handshake
   task automatic tick();
      @(negedge clock);
      if (pend) begin
         chk1("ready_low_after_accept", bit_ready, 1'b0);
         idx++;
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      if (idx < bits.size()) begin
         bit_valid = 1'b1;
         bit_in    = bits[idx];
      end
      pend = bit_valid && bit_ready;
   endtask

   task automatic run_frame(input int stop_at, input int mid_at);
      int lr;
      int wait_cnt;
      lr = (fl == 0) ? 1 : fl;
      build_model();
      div0    = CNT_W'(fd0);
      div1    = CNT_W'(fd1);
      sym_len = SYM_W'(fl);
      enable  = 1'b1;
      idx     = 0;
      pend    = 1'b0;
      wait_cnt = 0;
      do begin
         tick();
         wait_cnt++;
      end while (!busy && wait_cnt < 10);
      chki("start_latency", wait_cnt, 3);
      for (int c = 1; c <= bits.size() * lr; c++) begin
         if (c > 1) tick();
         chk1("busy_run", busy, 1'b1);
         chk1("busy_run_cp0", busy0, 1'b1);
         chk1("tone_cp1", tone_out, exp_t1[c - 1]);
         chk1("tone_cp0", tone_out0, exp_t0[c - 1]);
         chk1("sym_strobe", sym_strobe, (c % lr) == 0);
         chk1("sym_strobe_cp0", sym_strobe0, (c % lr) == 0);
         chk1("frame_done_run", frame_done, 1'b0);
         if (mid_at != 0 && c == mid_at) begin
            div0    = CNT_W'(2);
            sym_len = SYM_W'(25);
         end
         if (mid_at != 0 && c == mid_at + 20) begin
            div0    = CNT_W'(fd0);
            sym_len = SYM_W'(fl);
         end
         if (c == stop_at) return;
      end
      tick();
      chk1("busy_end", busy, 1'b0);
      chk1("frame_done", frame_done, 1'b1);
      chk1("frame_done_cp0", frame_done0, 1'b1);
      chk1("tone_end", tone_out, 1'b0);
      chk1("tone_end_cp0", tone_out0, 1'b0);
      tick();
      chk1("frame_done_pulse", frame_done, 1'b0);
      chk1("busy_idle", busy, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk1("rst_tone", tone_out, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_strobe", sym_strobe, 1'b0);
      chk1("rst_frame_done", frame_done, 1'b0);
      chk1("rst_ready", bit_ready, 1'b1);
      reset = 1'b1;
      @(negedge clock);

      bits = '{1'b0};
      fd0 = 15; fd1 = 7; fl = 64;
      run_frame(0, 0);

      bits = '{1'b0, 1'b1};
      fd0 = 15; fd1 = 7; fl = 64;
      run_frame(0, 10);

      bits = '{1'b0, 1'b1};
      fd0 = 15; fd1 = 3; fl = 10;
      run_frame(0, 0);

      bits = '{1'b1};
      fd0 = 4; fd1 = 0; fl = 0;
      run_frame(0, 0);

      for (int f = 0; f < 6; f++) begin
         bits.delete();
         repeat ($urandom_range(1, 4)) bits.push_back($urandom_range(0, 1) == 1);
         fd0 = $urandom_range(0, 9);
         fd1 = $urandom_range(0, 9);
         fl  = $urandom_range(2, 12);
         run_frame(0, 0);
      end

      // Abort with a bit waiting in the holding register
      bits = '{1'b0, 1'b1, 1'b1};
      fd0 = 5; fd1 = 2; fl = 20;
      run_frame(8, 0);
      enable    = 1'b0;
      bit_valid = 1'b0;
      pend      = 1'b0;
      @(negedge clock);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_tone", tone_out, 1'b0);
      chk1("abort_tone_cp0", tone_out0, 1'b0);
      chk1("abort_frame_done", frame_done, 1'b0);
      chk1("abort_ready", bit_ready, 1'b1);
      chk1("abort_strobe", sym_strobe, 1'b0);
      enable = 1'b1;
      repeat (3) begin
         @(negedge clock);
         chk1("abort_stays_idle", busy, 1'b0);
         chk1("abort_no_done", frame_done, 1'b0);
      end

      // Reset while the tone is high
      bits = '{1'b0};
      fd0 = 3; fd1 = 7; fl = 40;
      run_frame(6, 0);
      chk1("pre_reset_tone", tone_out, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk1("mid_rst_tone", tone_out, 1'b0);
      chk1("mid_rst_tone_cp0", tone_out0, 1'b0);
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_strobe", sym_strobe, 1'b0);
      chk1("mid_rst_frame_done", frame_done, 1'b0);
      bit_valid = 1'b0;
      pend      = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk1("post_rst_ready", bit_ready, 1'b1);
      chk1("post_rst_busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
